// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the 16x oversampled UART receiver.
package uart_pkg;

    localparam int DATA_W      = 8;
    localparam int OVERSAMPLE  = 16;
    localparam int SAMPLE_TICK = 7;
    localparam int TICK_W      = $clog2(OVERSAMPLE);
    localparam int IDX_W       = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_buf.sv
// First-word-fall-through receive FIFO with (ORDER+1)-bit wrap pointers.
// The head reads as zero while empty, so the byte output is clean during and after reset.
module uart_rx_buf
    import uart_pkg::*;
#(
    parameter int ORDER = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic [ORDER:0]    count,
    output logic              drop
);
    localparam int DEPTH = 2 ** ORDER;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ORDER:0]    wr_ptr_reg;
    logic [ORDER:0]    rd_ptr_reg;
    logic              full;
    logic              do_pop;
    logic              do_push;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[ORDER] != rd_ptr_reg[ORDER]) &&
                   (wr_ptr_reg[ORDER-1:0] == rd_ptr_reg[ORDER-1:0]);
    assign count = wr_ptr_reg - rd_ptr_reg;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & ~do_push;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg[ORDER-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign head = empty ? '0 : mem[rd_ptr_reg[ORDER-1:0]];

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver, 16x oversampled, feeding a FWFT receive FIFO with rts flow control.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at ticks 6/7/8 (decision at tick 8).
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int FIFO_ORDER = 4,
    parameter int RTS_SLACK  = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rx,
    output logic [DATA_W-1:0] out,
    input  logic              get,
    output logic              empty,
    output logic              rts,
    output logic              frame_err,
    output logic              overrun
);
    localparam logic [FIFO_ORDER:0] RTS_LEVEL = (FIFO_ORDER + 1)'(2 ** FIFO_ORDER - RTS_SLACK);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DATA_W - 1);

    logic                sync1_reg;
    logic                sync2_reg;
    logic                rx_prev_reg;
    logic                rx_s;
    rx_state_t           state_reg;
    rx_state_t           state_next;
    logic [TICK_W-1:0]   tick_reg;
    logic [TICK_W-1:0]   tick_next;
    logic [IDX_W-1:0]    idx_reg;
    logic [IDX_W-1:0]    idx_next;
    logic [DATA_W-1:0]   shift_reg;
    logic [DATA_W-1:0]   shift_next;
    logic                push;
    logic                frame_err_next;
    logic                frame_err_reg;
    logic                overrun_reg;
    logic                rts_reg;
    logic                sample;
    logic                at_sample;
    logic                drop;
    logic [FIFO_ORDER:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            sync1_reg   <= rx;
            sync2_reg   <= sync1_reg;
            rx_prev_reg <= sync2_reg;
        end
    end

    assign rx_s = sync2_reg;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [TICK_W-1:0] DECIDE_TICK = TICK_W'(SAMPLE_TICK + 1);

    logic s6_reg;
    logic s7_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s6_reg <= 1'b1;
            s7_reg <= 1'b1;
        end else begin
            if (tick_reg == TICK_W'(SAMPLE_TICK - 1)) begin
                s6_reg <= rx_s;
            end
            if (tick_reg == TICK_W'(SAMPLE_TICK)) begin
                s7_reg <= rx_s;
            end
        end
    end

    assign sample = majority3(s6_reg, s7_reg, rx_s);
`else
    localparam logic [TICK_W-1:0] DECIDE_TICK = TICK_W'(SAMPLE_TICK);

    assign sample = rx_s;
`endif

    assign at_sample = (tick_reg == DECIDE_TICK);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            tick_reg      <= '0;
            idx_reg       <= '0;
            shift_reg     <= '0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            rts_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tick_reg      <= tick_next;
            idx_reg       <= idx_next;
            shift_reg     <= shift_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= drop;
            rts_reg       <= (count >= RTS_LEVEL);
        end
    end

    // The edge-detect cycle counts as tick 0; the counter then free-runs mod 16,
    // so every later sample point lands exactly one bit period after the previous one.
    always_comb begin
        state_next     = state_reg;
        tick_next      = tick_reg + 1'b1;
        idx_next       = idx_reg;
        shift_next     = shift_reg;
        push           = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                tick_next = '0;
                if (rx_prev_reg && !rx_s) begin
                    state_next = START;
                    tick_next  = TICK_W'(1);
                end
            end
            START: begin
                if (at_sample) begin
                    if (sample) begin
                        state_next = IDLE;
                        tick_next  = '0;
                    end else begin
                        state_next = DATA;
                        idx_next   = '0;
                    end
                end
            end
            DATA: begin
                if (at_sample) begin
                    shift_next[idx_reg] = sample;
                    if (idx_reg == LAST_IDX) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                if (at_sample) begin
                    tick_next = '0;
                    if (sample) begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = BREAK;
                    end
                end
            end
            BREAK: begin
                tick_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                tick_next  = '0;
            end
        endcase
    end

    uart_rx_buf #(
        .ORDER(FIFO_ORDER)
    ) u_buf (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push),
        .push_data(shift_reg),
        .pop      (get),
        .head     (out),
        .empty    (empty),
        .count    (count),
        .drop     (drop)
    );

    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
    assign rts       = rts_reg;

endmodule
